// File: rtl/float_fix_pkg.sv
// Shared format constants, FSM state encoding and the unpacked-operand record
// for the float-to-fixed converter.
package float_fix_pkg;

   localparam int BIAS       = 127;
   localparam int FRAC_W     = 23;
   localparam int EXP_W      = 8;
   localparam int MAX_LSHIFT = 8;
   localparam int MAX_RSHIFT = 25;

   localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_NEG = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_SHIFT,
      ST_PACK,
      ST_DONE
   } state_e;

   // Decoded operand: fields, special-case flags and the clamped shift plan.
   typedef struct packed {
      logic              sign;
      logic [FRAC_W:0]   mant;       // hidden 1 plus fraction
      logic              is_zero;    // zero or denormal
      logic              is_nan;
      logic              is_inf;
      logic              left;       // shift direction, 1 = left
      logic [4:0]        cnt;        // clamped shift count
      logic              clamp_ovf;  // left shift beyond the clamp: certain overflow
   } unpack_t;

endpackage

// File: rtl/f2x_unpack.sv
// Combinational operand decode: splits the IEEE-754 single into fields, flags
// zero/denormal, NaN and Inf, and turns exp - 150 + fixpointpos into a clamped
// one-direction shift count for the iterative aligner.
module f2x_unpack
   import float_fix_pkg::*;
(
   input  logic [31:0] operand_i,
   input  logic [4:0]  fixpointpos_i,
   output unpack_t     fields_o
);

   localparam logic signed [9:0] EXP_OFFSET = 10'(BIAS + FRAC_W);
   localparam logic signed [9:0] LCLAMP     = 10'(MAX_LSHIFT);
   localparam logic signed [9:0] RCLAMP     = 10'(MAX_RSHIFT);

   logic [EXP_W-1:0]  exp_w;
   logic [FRAC_W-1:0] frac_w;
   logic signed [9:0] shift_s;
   logic signed [9:0] neg_s;

   assign exp_w   = operand_i[30:23];
   assign frac_w  = operand_i[22:0];
   // Range is -150..136, so ten signed bits never wrap.
   assign shift_s = $signed({2'b00, exp_w}) - EXP_OFFSET + $signed({5'b00000, fixpointpos_i});
   assign neg_s   = -shift_s;

   // Field split, special decode and shift-count clamping.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      fields_o           = '0;
      fields_o.sign      = operand_i[31];
      fields_o.mant      = {1'b1, frac_w};
      fields_o.is_zero   = (exp_w == '0);
      fields_o.is_nan    = (exp_w == '1) && (frac_w != '0);
      fields_o.is_inf    = (exp_w == '1) && (frac_w == '0);
      if (shift_s > 10'sd0) begin
         fields_o.left = 1'b1;
         if (shift_s > LCLAMP) begin
            fields_o.cnt       = LCLAMP[4:0];
            fields_o.clamp_ovf = 1'b1;
         end else begin
            fields_o.cnt = shift_s[4:0];
         end
      end else begin
         fields_o.left = 1'b0;
         if (neg_s > RCLAMP) fields_o.cnt = RCLAMP[4:0];
         else                fields_o.cnt = neg_s[4:0];
      end
   end

endmodule

// File: rtl/float_to_fixed.sv
// IEEE-754 single to 32-bit signed fixed point with a runtime binary point.
// Alignment is one bit per cycle; valid/ready on both sides, one operand in
// flight. Define FLOAT2FIX_ROUND_EN for round-to-nearest-even, otherwise the
// magnitude is truncated toward zero.
module float_to_fixed
   import float_fix_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] targetnumber,
   input  logic [4:0]  fixpointpos,
   output logic [31:0] result,
   output logic        overflow,
   output logic        out_valid,
   input  logic        out_ready
);

   state_e      state_q, state_d;
   logic [31:0] op_q, op_d;
   logic [4:0]  fp_q, fp_d;
   logic        sign_q, sign_d;
   logic        nan_q, nan_d;
   logic        ovf_q, ovf_d;       // magnitude known to exceed the range
   logic        left_q, left_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mag_q, mag_d;
   logic [31:0] result_q, result_d;
   logic        ovf_out_q, ovf_out_d;

   unpack_t     fields;
   logic [32:0] mag_rnd;            // magnitude after optional rounding, carry kept
   logic [31:0] pack_res;
   logic        pack_ovf;

   f2x_unpack u_unpack (
      .operand_i     (op_q),
      .fixpointpos_i (fp_q),
      .fields_o      (fields)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign overflow  = ovf_out_q;

`ifdef FLOAT2FIX_ROUND_EN
   logic guard_q, guard_d, sticky_q, sticky_d, round_up;

   // Guard/sticky tracking: cleared on unpack, fed by each right shift.
   always_comb begin
      guard_d  = guard_q;
      sticky_d = sticky_q;
      if (state_q == ST_UNPACK) begin
         guard_d  = 1'b0;
         sticky_d = 1'b0;
      end else if (state_q == ST_SHIFT && !left_q) begin
         guard_d  = mag_q[0];
         sticky_d = sticky_q | guard_q;
      end
   end

   // Guard/sticky registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
      end
   end

   // Ties go to the even neighbour.
   assign round_up = guard_q & (sticky_q | mag_q[0]);
   assign mag_rnd  = {1'b0, mag_q} + {32'd0, round_up};
`else
   assign mag_rnd  = {1'b0, mag_q};
`endif

   // Saturation and sign application on the (rounded) magnitude.
   always_comb begin
      pack_res = mag_rnd[31:0];
      pack_ovf = 1'b0;
      if (nan_q) begin
         pack_res = '0;
         pack_ovf = 1'b1;
      end else if (!sign_q) begin
         if (ovf_q || mag_rnd >= 33'h0_8000_0000) begin
            pack_res = SAT_POS;
            pack_ovf = 1'b1;
         end
      end else begin
         // -2^31 is representable, so only strictly larger magnitudes saturate.
         if (ovf_q || mag_rnd > 33'h0_8000_0000) begin
            pack_res = SAT_NEG;
            pack_ovf = 1'b1;
         end else begin
            pack_res = -mag_rnd[31:0];
         end
      end
   end

   // FSM next state and datapath updates.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      fp_d      = fp_q;
      sign_d    = sign_q;
      nan_d     = nan_q;
      ovf_d     = ovf_q;
      left_d    = left_q;
      cnt_d     = cnt_q;
      mag_d     = mag_q;
      result_d  = result_q;
      ovf_out_d = ovf_out_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d    = targetnumber;
               fp_d    = fixpointpos;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            sign_d = fields.sign;
            nan_d  = fields.is_nan;
            ovf_d  = fields.clamp_ovf;
            left_d = fields.left;
            cnt_d  = fields.cnt;
            mag_d  = {8'd0, fields.mant};
            if (fields.is_zero || fields.is_nan || fields.is_inf) begin
               // Inf saturates by sign through the overflow flag; NaN and zero pack to 0.
               mag_d   = '0;
               cnt_d   = '0;
               ovf_d   = fields.is_inf;
               state_d = ST_PACK;
            end else if (fields.cnt == '0) begin
               state_d = ST_PACK;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cnt_d = cnt_q - 5'd1;
            if (left_q) begin
               mag_d = {mag_q[30:0], 1'b0};
               // Top bit set with shifts still pending means the value is past 2^31.
               if (mag_d[31] && cnt_d != '0) begin
                  ovf_d   = 1'b1;
                  state_d = ST_PACK;
               end else if (cnt_d == '0) begin
                  state_d = ST_PACK;
               end
            end else begin
               mag_d = {1'b0, mag_q[31:1]};
               if (cnt_d == '0) state_d = ST_PACK;
            end
         end
         ST_PACK: begin
            result_d  = pack_res;
            ovf_out_d = pack_ovf;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operand in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         fp_q      <= '0;
         sign_q    <= 1'b0;
         nan_q     <= 1'b0;
         ovf_q     <= 1'b0;
         left_q    <= 1'b0;
         cnt_q     <= '0;
         mag_q     <= '0;
         result_q  <= '0;
         ovf_out_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state_q   <= state_d;
         op_q      <= op_d;
         fp_q      <= fp_d;
         sign_q    <= sign_d;
         nan_q     <= nan_d;
         ovf_q     <= ovf_d;
         left_q    <= left_d;
         cnt_q     <= cnt_d;
         mag_q     <= mag_d;
         result_q  <= result_d;
         ovf_out_q <= ovf_out_d;
      end
   end

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed and randomized bench for float_to_fixed. Expected values come from
// an integer model of the float value scaled by 2^fixpointpos.
module tb_float_to_fixed;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] targetnumber;
   logic [4:0]  fixpointpos;
   logic [31:0] result;
   logic        overflow;
   logic        out_valid;
   logic        out_ready;

   int vectors     = 0;
   int miscompares = 0;

`ifdef FLOAT2FIX_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   float_to_fixed dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .targetnumber (targetnumber),
      .fixpointpos  (fixpointpos),
      .result       (result),
      .overflow     (overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value = mant * 2^s with s = exp - 150 + fp; exact integer arithmetic.
   function automatic void model(input logic [31:0] op, input int fp,
                                 output logic [31:0] res, output logic ovf, output int n);
      int     e, s, r;
      longint mant, q, rem, half;
      bit     big;
      e    = int'(op[30:23]);
      mant = longint'({1'b1, op[22:0]});
      res  = '0;
      ovf  = 1'b0;
      n    = 0;
      big  = 1'b0;
      q    = 0;
      if (e == 0) return;
      if (e == 255) begin
         ovf = 1'b1;
         if (op[22:0] != 0) res = 32'h0;
         else res = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         return;
      end
      s = e - 150 + fp;
      if (s >= 0) begin
         n = (s > 8) ? 8 : s;
         if (s > 8) big = 1'b1;
         else q = mant << s;
      end else begin
         r = -s;
         n = (r > 25) ? 25 : r;
         if (r <= 40) begin
            q    = mant >> r;
            rem  = mant - (q << r);
            half = longint'(1) << (r - 1);
            if (ROUND_EN && (rem > half || (rem == half && q[0]))) q = q + 1;
         end
      end
      if (!op[31]) begin
         if (big || q >= 64'h8000_0000) begin res = 32'h7FFF_FFFF; ovf = 1'b1; end
         else res = q[31:0];
      end else begin
         if (big || q > 64'h8000_0000) begin res = 32'h8000_0000; ovf = 1'b1; end
         else res = 32'(-q);
      end
   endfunction

   // Offer one operand, then wait (bounded) for out_valid; lat counts cycles from accept.
   task automatic run(input logic [31:0] op, input logic [4:0] fp, input bit ready_early,
                      output logic [31:0] res, output logic ovf, output int lat);
      int wait_cnt;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
         tick();
         wait_cnt++;
      end
      targetnumber = op;
      fixpointpos  = fp;
      in_valid     = 1'b1;
      out_ready    = ready_early;
      tick();
      in_valid     = 1'b0;
      targetnumber = $urandom;
      fixpointpos  = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 60) begin
         tick();
         lat++;
      end
      res = result;
      ovf = overflow;
   endtask

   // Complete the output handshake and confirm the block is ready again.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      check(tag, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [31:0] op, input logic [4:0] fp,
                           input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
      logic [31:0] r;
      logic        o;
      int          l;
      run(op, fp, 1'b0, r, o, l);
      check({tag, "_res"}, r, exp_res);
      check({tag, "_ovf"}, 32'(o), 32'(exp_ovf));
      check({tag, "_lat"}, 32'(l), 32'(exp_lat));
      drain({tag, "_rdy"});
   endtask

   initial begin
      logic [31:0] r;
      logic        o;
      int          l;

      rst          = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      targetnumber = '0;
      fixpointpos  = '0;
      repeat (3) tick();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    result,         32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      rst = 1'b1;
      tick();

      directed("one_p5",     32'h3FC0_0000, 5'd8,  32'h0000_0180, 1'b0, 18);
      directed("neg_2p25",   32'hC010_0000, 5'd4,  32'hFFFF_FFDC, 1'b0, 21);
      directed("pos_2p31",   32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 11);
      directed("neg_2p31",   32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b0, 11);
      directed("huge_clamp", 32'h7F00_0000, 5'd31, 32'h7FFF_FFFF, 1'b1, 11);
      directed("nan",        32'h7FC0_0000, 5'd5,  32'h0000_0000, 1'b1, 3);
      directed("neg_inf",    32'hFF80_0000, 5'd0,  32'h8000_0000, 1'b1, 3);
      directed("zero",       32'h0000_0000, 5'd9,  32'h0000_0000, 1'b0, 3);
      directed("no_shift",   32'h3F80_0000, 5'd23, 32'h0080_0000, 1'b0, 3);
      directed("tiny_max_r", 32'h3300_0000, 5'd0,  32'h0000_0000, 1'b0, 28);
      directed("p75",        32'h3F40_0000, 5'd0,  ROUND_EN ? 32'd1 : 32'd0, 1'b0, 27);
      directed("p5_tie",     32'h3F00_0000, 5'd0,  32'h0000_0000, 1'b0, 27);

      // Backpressure: output held, no new accept while the consumer stalls.
      run(32'h3FC0_0000, 5'd8, 1'b0, r, o, l);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_result",    result,         32'h0000_0180);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      drain("bp_rdy");

      // out_ready already high: handshake in the first DONE cycle.
      run(32'hC010_0000, 5'd4, 1'b1, r, o, l);
      check("early_res", r, 32'hFFFF_FFDC);
      tick();
      check("early_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b0;

      // Reset in the middle of the alignment shifts.
      targetnumber = 32'h3FC0_0000;
      fixpointpos  = 5'd8;
      in_valid     = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_result",    result,         32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      directed("postrst", 32'hC010_0000, 5'd4, 32'hFFFF_FFDC, 1'b0, 21);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] op, er;
         logic [4:0]  fp;
         logic        eo;
         int          en, sel, e;
         sel = $urandom_range(0, 9);
         if (sel == 0)      e = 0;
         else if (sel == 1) e = 255;
         else               e = $urandom_range(100, 165);
         op = {1'($urandom), 8'(e), 23'($urandom)};
         fp = 5'($urandom);
         model(op, int'(fp), er, eo, en);
         run(op, fp, 1'($urandom), r, o, l);
         check("rnd_res", r, er);
         check("rnd_ovf", 32'(o), 32'(eo));
         check("rnd_lat", 32'(l), 32'(3 + en));
         drain("rnd_rdy");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
